// File: rtl/plat_scan_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// plat_scan_ctrl_pkg : shared constants, FSM encoding, packed-bus helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package plat_scan_ctrl_pkg;

    localparam int TILE_W      = 8;
    localparam int CHAR_W      = 16;
    localparam int MAX_BUS_W   = 1024;
    localparam int MAX_FIELD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Returns field `idx` of width `w` from a bus zero-extended to MAX_BUS_W.
    function automatic logic [MAX_FIELD_W-1:0] field_at(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_FIELD_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = (w >= MAX_FIELD_W) ? '1 : ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
        return shifted[MAX_FIELD_W-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plat_hit_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// plat_hit_check : combinational landing test of one platform vs trajectory
// Rev 1.0
// ---------------------------------------------------------------------------
module plat_hit_check
    import plat_scan_ctrl_pkg::*;
#(
    parameter int PHY_WIDTH       = 16,
    parameter int BLOCK_LEN_WIDTH = 4
) (
    input  logic [PHY_WIDTH-1:0]       i_px,
    input  logic [PHY_WIDTH-1:0]       i_py,
    input  logic [BLOCK_LEN_WIDTH-1:0] i_len,
    input  logic [PHY_WIDTH-1:0]       i_char_x,
    input  logic [PHY_WIDTH-1:0]       i_foot_y,
    input  logic [PHY_WIDTH-1:0]       i_next_foot_y,
    output logic                       o_hit
);

    logic [PHY_WIDTH-1:0] w_span;
    logic [PHY_WIDTH:0]   w_char_r;
    logic [PHY_WIDTH:0]   w_plat_r;
    logic                 w_horiz;
    logic                 w_vert;

    // Span is deliberately kept at PHY_WIDTH; only the edge sums get a guard bit.
    assign w_span   = PHY_WIDTH'(i_len) * PHY_WIDTH'(TILE_W);
    assign w_char_r = {1'b0, i_char_x} + (PHY_WIDTH+1)'(CHAR_W);
    assign w_plat_r = {1'b0, i_px} + {1'b0, w_span};

    assign w_horiz = (w_char_r > {1'b0, i_px}) && ({1'b0, i_char_x} < w_plat_r);
    // Crossing the top surface downward implies next < foot, so rising never hits.
    assign w_vert  = (i_foot_y >= i_py) && (i_next_foot_y < i_py);

    assign o_hit = w_horiz && w_vert;

endmodule
`default_nettype wire

// File: rtl/plat_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// plat_scan_ctrl : sequential per-platform landing scan, one platform/cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module plat_scan_ctrl
    import plat_scan_ctrl_pkg::*;
#(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 16,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int IDX_WIDTH              = 3
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst_n,
    input  logic                                          start,
    input  logic [PHY_WIDTH-1:0]                          char_x,
    input  logic [PHY_WIDTH-1:0]                          foot_y,
    input  logic [PHY_WIDTH-1:0]                          next_foot_y,
    input  logic                                          block_switch,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          hit,
    output logic [IDX_WIDTH-1:0]                          hit_idx,
    output logic [PHY_WIDTH-1:0]                          land_y
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(PLATFORM_NUM_PER_BLOCK - 1);

    scan_state_t          r_state;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [PHY_WIDTH-1:0] r_char_x;
    logic [PHY_WIDTH-1:0] r_foot_y;
    logic [PHY_WIDTH-1:0] r_next_y;
    logic                 r_whit;
    logic [IDX_WIDTH-1:0] r_widx;
    logic [PHY_WIDTH-1:0] r_wy;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_hit;
    logic [IDX_WIDTH-1:0] r_hit_idx;
    logic [PHY_WIDTH-1:0] r_land_y;

    logic [PHY_WIDTH-1:0]       w_px;
    logic [PHY_WIDTH-1:0]       w_py;
    logic [BLOCK_LEN_WIDTH-1:0] w_len;
    logic                       w_plat_hit;
    logic                       w_take;

    assign w_px  = PHY_WIDTH'(field_at(MAX_BUS_W'(plat_relative_x), 32'(r_idx), PHY_WIDTH));
    assign w_py  = PHY_WIDTH'(field_at(MAX_BUS_W'(plat_relative_y), 32'(r_idx), PHY_WIDTH));
    assign w_len = BLOCK_LEN_WIDTH'(field_at(MAX_BUS_W'(plat_len), 32'(r_idx), BLOCK_LEN_WIDTH));

    plat_hit_check #(
        .PHY_WIDTH       (PHY_WIDTH),
        .BLOCK_LEN_WIDTH (BLOCK_LEN_WIDTH)
    ) u_hit_check (
        .i_px          (w_px),
        .i_py          (w_py),
        .i_len         (w_len),
        .i_char_x      (r_char_x),
        .i_foot_y      (r_foot_y),
        .i_next_foot_y (r_next_y),
        .o_hit         (w_plat_hit)
    );

    // Strictly-greater replacement keeps the lower index on equal heights.
    assign w_take = w_plat_hit && (!r_whit || (w_py > r_wy));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_char_x  <= '0;
            r_foot_y  <= '0;
            r_next_y  <= '0;
            r_whit    <= 1'b0;
            r_widx    <= '0;
            r_wy      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
            r_land_y  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_char_x  <= char_x;
                        r_foot_y  <= foot_y;
                        r_next_y  <= next_foot_y;
                        r_whit    <= 1'b0;
                        r_widx    <= '0;
                        r_wy      <= '0;
                        r_hit     <= 1'b0;
                        r_hit_idx <= '0;
                        r_land_y  <= '0;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (block_switch) begin
                        r_idx  <= '0;
                        r_whit <= 1'b0;
                        r_widx <= '0;
                        r_wy   <= '0;
                    end else begin
                        if (w_take) begin
                            r_whit <= 1'b1;
                            r_widx <= r_idx;
                            r_wy   <= w_py;
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_hit     <= w_take || r_whit;
                            r_hit_idx <= w_take ? r_idx : r_widx;
                            r_land_y  <= w_take ? w_py  : r_wy;
                        end else begin
                            r_idx <= r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hit     = r_hit;
    assign hit_idx = r_hit_idx;
    assign land_y  = r_land_y;

endmodule
`default_nettype wire

// File: tb/tb_plat_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_plat_scan_ctrl : scenario tasks plus randomized scans vs reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_plat_scan_ctrl;

    localparam int N   = 7;
    localparam int PW  = 16;
    localparam int LW  = 4;
    localparam int IW  = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start = 1'b0;
    logic [PW-1:0]     char_x = '0;
    logic [PW-1:0]     foot_y = '0;
    logic [PW-1:0]     next_foot_y = '0;
    logic              block_switch = 1'b0;
    logic [N*PW-1:0]   plat_relative_x;
    logic [N*PW-1:0]   plat_relative_y;
    logic [N*LW-1:0]   plat_len;
    logic              busy;
    logic              done;
    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic [PW-1:0]     land_y;

    int unsigned m_px[N];
    int unsigned m_py[N];
    int unsigned m_pl[N];
    int unsigned p_px[N];
    int unsigned p_py[N];
    int unsigned p_pl[N];

    int n_checks = 0;
    int n_errors = 0;

    plat_scan_ctrl #(
        .PLATFORM_NUM_PER_BLOCK (N),
        .PHY_WIDTH              (PW),
        .BLOCK_LEN_WIDTH        (LW),
        .IDX_WIDTH              (IW)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .start           (start),
        .char_x          (char_x),
        .foot_y          (foot_y),
        .next_foot_y     (next_foot_y),
        .block_switch    (block_switch),
        .plat_relative_x (plat_relative_x),
        .plat_relative_y (plat_relative_y),
        .plat_len        (plat_len),
        .busy            (busy),
        .done            (done),
        .hit             (hit),
        .hit_idx         (hit_idx),
        .land_y          (land_y)
    );

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        plat_relative_x = '0;
        plat_relative_y = '0;
        plat_len        = '0;
        for (int i = 0; i < N; i++) begin
            plat_relative_x[i*PW +: PW] = PW'(m_px[i]);
            plat_relative_y[i*PW +: PW] = PW'(m_py[i]);
            plat_len[i*LW +: LW]        = LW'(m_pl[i]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: highest crossed top surface wins, earliest index on ties.
    function automatic void model(output bit h, output int idx, output int y);
        int unsigned span, cx, fy, ny;
        h = 0; idx = 0; y = 0;
        cx = char_x; fy = foot_y; ny = next_foot_y;
        for (int i = 0; i < N; i++) begin
            span = (m_pl[i] * 8) % 65536;
            if ((cx + 16 > m_px[i]) && (cx < m_px[i] + span) &&
                (fy >= m_py[i]) && (ny < m_py[i])) begin
                if (!h || int'(m_py[i]) > y) begin
                    h = 1; idx = i; y = int'(m_py[i]);
                end
            end
        end
    endfunction

    task automatic set_far();
        for (int i = 0; i < N; i++) begin
            m_px[i] = 1000; m_py[i] = 400; m_pl[i] = 2;
        end
    endtask

    task automatic set_char(input int cx, input int fy, input int ny);
        char_x = PW'(cx); foot_y = PW'(fy); next_foot_y = PW'(ny);
    endtask

    // Launches a scan and observes for 30 cycles; cycle 0 is the start cycle.
    task automatic do_scan(input int bs_cyc, input int st2_cyc,
                           output int lat, output int ndone, output bit busy_after);
        lat = -1; ndone = 0; busy_after = 1'b1;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            block_switch = (c == bs_cyc);
            if (c == bs_cyc) begin
                m_px = p_px; m_py = p_py; m_pl = p_pl;
            end
            start = (c == st2_cyc);
            if (done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c == lat + 1) busy_after = busy;
            @(posedge sys_clk); #1;
        end
        block_switch = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL reset_hit: got %0b expected 0", hit); end
        n_checks++; if (hit_idx !== '0) begin n_errors++; $display("FAIL reset_hit_idx: got %0d expected 0", hit_idx); end
        n_checks++; if (land_y !== '0) begin n_errors++; $display("FAIL reset_land_y: got %0d expected 0", land_y); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_single_hit();
        int lat, nd; bit ba;
        set_far();
        m_px[0] = 280; m_py[0] = 35; m_pl[0] = 10;
        set_char(300, 40, 30);
        do_scan(0, 0, lat, nd, ba);
        n_checks++; if (lat !== 8) begin n_errors++; $display("FAIL single_latency: got %0d expected 8", lat); end
        n_checks++; if (hit !== 1'b1) begin n_errors++; $display("FAIL single_hit: got %0b expected 1", hit); end
        n_checks++; if (hit_idx !== 3'd0) begin n_errors++; $display("FAIL single_idx: got %0d expected 0", hit_idx); end
        n_checks++; if (land_y !== 16'd35) begin n_errors++; $display("FAIL single_land_y: got %0d expected 35", land_y); end
    endtask

    task automatic test_miss();
        int lat, nd; bit ba;
        set_char(100, 40, 30);
        do_scan(0, 0, lat, nd, ba);
        n_checks++; if (lat !== 8) begin n_errors++; $display("FAIL miss_latency: got %0d expected 8", lat); end
        n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL miss_hit: got %0b expected 0", hit); end
        n_checks++; if (ba !== 1'b0) begin n_errors++; $display("FAIL miss_busy_after: got %0b expected 0", ba); end
    endtask

    task automatic test_priority();
        int lat, nd; bit ba;
        set_far();
        m_px[0] = 280; m_py[0] = 35; m_pl[0] = 10;
        m_px[2] = 100; m_py[2] = 150; m_pl[2] = 8;
        m_px[5] = 100; m_py[5] = 150; m_pl[5] = 8;
        set_char(110, 160, 140);
        do_scan(0, 0, lat, nd, ba);
        n_checks++; if (hit !== 1'b1) begin n_errors++; $display("FAIL prio_tie_hit: got %0b expected 1", hit); end
        n_checks++; if (hit_idx !== 3'd2) begin n_errors++; $display("FAIL prio_tie_idx: got %0d expected 2", hit_idx); end
        n_checks++; if (land_y !== 16'd150) begin n_errors++; $display("FAIL prio_tie_land_y: got %0d expected 150", land_y); end
        m_py[5] = 155;
        do_scan(0, 0, lat, nd, ba);
        n_checks++; if (hit_idx !== 3'd5) begin n_errors++; $display("FAIL prio_high_idx: got %0d expected 5", hit_idx); end
        n_checks++; if (land_y !== 16'd155) begin n_errors++; $display("FAIL prio_high_land_y: got %0d expected 155", land_y); end
    endtask

    task automatic test_rising();
        int lat, nd; bit ba;
        set_far();
        m_px[0] = 280; m_py[0] = 35; m_pl[0] = 10;
        set_char(300, 30, 40);
        do_scan(0, 0, lat, nd, ba);
        n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL rising_hit: got %0b expected 0", hit); end
    endtask

    task automatic test_restart();
        int lat, nd, eidx, ey; bit ba, eh;
        set_far();
        m_px[0] = 280; m_py[0] = 35; m_pl[0] = 10;
        p_px = m_px; p_py = m_py; p_pl = m_pl;
        p_px[0] = 1000; p_py[0] = 400;
        p_px[4] = 290;  p_py[4] = 38; p_pl[4] = 5;
        set_char(300, 40, 30);
        do_scan(3, 5, lat, nd, ba);
        model(eh, eidx, ey);
        n_checks++; if (lat !== 11) begin n_errors++; $display("FAIL restart_latency: got %0d expected 11", lat); end
        n_checks++; if (nd !== 1) begin n_errors++; $display("FAIL restart_done_count: got %0d expected 1", nd); end
        n_checks++; if (hit !== eh) begin n_errors++; $display("FAIL restart_hit: got %0b expected %0b", hit, eh); end
        n_checks++; if (int'(hit_idx) !== eidx) begin n_errors++; $display("FAIL restart_idx: got %0d expected %0d", hit_idx, eidx); end
        n_checks++; if (int'(land_y) !== ey) begin n_errors++; $display("FAIL restart_land_y: got %0d expected %0d", land_y, ey); end
    endtask

    task automatic test_reset_mid_scan();
        int nd;
        set_far();
        m_px[0] = 280; m_py[0] = 35; m_pl[0] = 10;
        set_char(300, 40, 30);
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy_before: got %0b expected 1", busy); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done: got %0b expected 0", done); end
        n_checks++; if (hit !== 1'b0) begin n_errors++; $display("FAIL midrst_hit: got %0b expected 0", hit); end
        n_checks++; if (hit_idx !== '0) begin n_errors++; $display("FAIL midrst_idx: got %0d expected 0", hit_idx); end
        n_checks++; if (land_y !== '0) begin n_errors++; $display("FAIL midrst_land_y: got %0d expected 0", land_y); end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge sys_clk); #1;
            if (done) nd++;
        end
        n_checks++; if (nd !== 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d expected 0", nd); end
    endtask

    task automatic test_random();
        int lat, nd, eidx, ey, base, mode; bit ba, eh;
        for (int it = 0; it < 25; it++) begin
            mode = int'($urandom_range(0, 3));
            base = (mode == 3) ? 65300 : 0;
            for (int i = 0; i < N; i++) begin
                m_px[i] = base + $urandom_range(0, 200);
                m_py[i] = $urandom_range(0, 10) * 20;
                m_pl[i] = $urandom_range(0, 15);
            end
            foot_y      = PW'($urandom_range(0, 220));
            next_foot_y = (mode == 2) ? PW'(int'(foot_y) + int'($urandom_range(0, 20)))
                                      : PW'(int'(foot_y) - int'($urandom_range(0, int'(foot_y) < 60 ? int'(foot_y) : 60)));
            char_x      = PW'(base + int'($urandom_range(0, 230)));
            do_scan(0, 0, lat, nd, ba);
            model(eh, eidx, ey);
            n_checks++; if (lat !== 8) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected 8", it, lat); end
            n_checks++; if (hit !== eh) begin n_errors++; $display("FAIL rand_hit[%0d]: got %0b expected %0b", it, hit, eh); end
            if (eh) begin
                n_checks++; if (int'(hit_idx) !== eidx) begin n_errors++; $display("FAIL rand_idx[%0d]: got %0d expected %0d", it, hit_idx, eidx); end
                n_checks++; if (int'(land_y) !== ey) begin n_errors++; $display("FAIL rand_land_y[%0d]: got %0d expected %0d", it, land_y, ey); end
            end
        end
    endtask

    initial begin
        set_far();
        test_reset();
        test_single_hit();
        test_miss();
        test_priority();
        test_rising();
        test_restart();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plat_scan_ctrl.md
Name: plat_scan_ctrl

Overview:
Sequential landing-detection controller for the platform layout produced by the block generator. On each physics tick it scans the current block's PLATFORM_NUM_PER_BLOCK platforms one per cycle against the character's falling trajectory. It reports whether a landing occurs, on which platform, and at what height.
- Sits between the block generator (platform buses, block_switch) and the physics/jump FSM, which issues start and consumes done.
- Lets one comparator be time-shared instead of instantiating one per platform.

Parameters:
PLATFORM_NUM_PER_BLOCK, 7, platforms per block; scan length.
PHY_WIDTH, 16, width of each packed x/y field and of character coordinates.
BLOCK_LEN_WIDTH, 4, width of each packed platform length field, in tiles.
IDX_WIDTH, 3, width of the platform index; must satisfy 2^IDX_WIDTH >= PLATFORM_NUM_PER_BLOCK.

Ports:
sys_clk  in  1  system clock; all state changes on rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
char_x  in  PHY_WIDTH  character left edge, block-relative.
foot_y  in  PHY_WIDTH  current foot height, block-relative; y increases upward.
next_foot_y  in  PHY_WIDTH  predicted foot height after this tick.
block_switch  in  1  block generator changed block; platform buses are changing.
plat_relative_x  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform left x.
plat_relative_y  in  PLATFORM_NUM_PER_BLOCK*PHY_WIDTH  packed platform top y.
plat_len  in  PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH  packed platform length in tiles.
busy  out  1  high in SCAN and DONE.
done  out  1  one-cycle pulse; scan result valid.
hit  out  1  a landing was found.
hit_idx  out  IDX_WIDTH  index of the landing platform.
land_y  out  PHY_WIDTH  top y of the landing platform.

Behaviour:
- Reset (asynchronous, any state, including mid-scan):
  - state = IDLE, idx = 0.
  - busy = 0, done = 0, hit = 0, hit_idx = 0, land_y = 0.
  - Latched character registers = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If start is sampled high at edge k: latch char_x, foot_y and next_foot_y; clear the working hit/idx/y registers; enter SCAN with idx = 0.
  - Otherwise stay in IDLE.
- SCAN:
  - At each edge, evaluate platform idx from the live buses using the latched character values.
  - If idx = PLATFORM_NUM_PER_BLOCK-1, go to DONE; otherwise increment idx.
  - Platforms are evaluated at edges k+1 through k+PLATFORM_NUM_PER_BLOCK.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - done = 1 during this cycle only: 8 cycles after the start edge with the default parameter.
  - hit, hit_idx and land_y are published on entry to DONE and held until the next accepted start clears them.
- Hit test for platform i, with px = x field, py = y field, span = len*TILE_W:
  - Horizontal: char_x + CHAR_W > px and char_x < px + span.
  - Vertical: foot_y >= py and next_foot_y < py, i.e. the trajectory crosses the top surface while falling.
  - A rising or stationary trajectory (next_foot_y >= foot_y) never hits.
- Arithmetic:
  - All comparisons are unsigned at PHY_WIDTH+1 bits so the additions cannot wrap.
  - len*TILE_W is computed at PHY_WIDTH bits.
- Multiple hits: keep the one with the highest py, since it is crossed first. On equal py, the lower index wins; it was scanned first, so replace only on strictly greater py.
- block_switch:
  - High during SCAN: discard partial results, set idx = 0 and continue scanning, i.e. restart. The latched character values are kept.
  - High in IDLE or DONE: no effect.
  - High on the same edge that would move SCAN to DONE: the restart wins and no done is issued.
- start while busy is ignored, not queued.
- start and block_switch high on the same IDLE edge: start is accepted normally.

Decomposition:
- Shared package holds:
  - TILE_W = 8 and CHAR_W = 16 (pixel constants).
  - State encoding IDLE/SCAN/DONE as a 2-bit enumerated type.
  - Field-extract helper functions for the packed platform buses.
- One natural sub-module: plat_hit_check. It is the combinational comparator taking px, py, len and the character values, and producing a hit flag. It is instantiated once, with its inputs muxed by idx.

Test Plan:
1. Single hit. Bus entry 0 = (x280, y35, len10), all others with y = 400 and out of range in x. Stimulus: char_x=300, foot_y=40, next_foot_y=30, pulse start. Required: done exactly 8 cycles after start, hit=1, hit_idx=0, land_y=35.
2. Miss. Same buses, char_x=100. Required: done after 8 cycles, hit=0, busy=0 on the following cycle.
3. Priority. Entry 2 = (x100, y150, len8) and entry 5 = (x100, y150, len8), with char_x=110, foot_y=160, next_foot_y=140. Required: hit_idx=2, land_y=150. Then change entry 5 to y155 with foot_y=160. Required: hit_idx=5, land_y=155.
4. Rising trajectory. Stimulus: foot_y=30, next_foot_y=40 over entry 0 of test 1. Required: hit=0.
5. Restart. Pulse block_switch 3 cycles after start. Required: done 11 cycles after start; result reflects the full set of new bus values. A second start pulsed while busy is ignored, giving exactly one done.
6. Reset mid-scan. Assert sys_rst_n low 4 cycles into a scan. Required: busy, done, hit, hit_idx and land_y are 0 immediately with no clock edge, and no done appears after release.
